fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 31 +++
 rtl/fetch_ctrl.sv | 97 +++++++++
 tb/tb_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory request channel plus the
// decode-side presentation/consume handshake.
interface fetch_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic [WIDTH-1:0] instr;
    logic             instr_valid;
    logic             instr_ready;
    logic             stall;
    logic             PCSrc;
    logic [WIDTH-1:0] ImmExt;
    logic [WIDTH-1:0] PC;
    logic             trap;
    logic [WIDTH-1:0] retired;

    // Fetch controller side
    modport master (
        output imem_req, imem_addr, instr, instr_valid, PC, trap, retired,
        input  imem_ack, imem_rdata, instr_ready, stall, PCSrc, ImmExt
    );

    // Memory / decode environment side
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, PC, trap, retired,
        output imem_ack, imem_rdata, instr_ready, stall, PCSrc, ImmExt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory read, holds the returned
// instruction for decode until consumed, then computes the next fetch
// address (sequential or branch). A misaligned target parks the unit in TRAP
// until reset.
module fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        TRAP
    } state_t;

    localparam logic [WIDTH-1:0] SEQ_STEP = WIDTH'(4);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] retired_q, retired_d;
    logic [WIDTH-1:0] target;
    logic             consume;

    // State and datapath registers; reset forces the boot image immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            retired_q  <= retired_d;
        end
    end

    // Next-state and datapath updates; branch inputs only matter on consume
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        retired_d  = retired_q;
        consume    = (state_q == HOLD) && bus.instr_ready && !bus.stall;
        target     = pc_q + (bus.PCSrc ? bus.ImmExt : SEQ_STEP);

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    pc_d    = fetch_pc_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (consume) begin
                    retired_d = retired_q + 1'b1;
                    if (target[1:0] == 2'b00) begin
                        fetch_pc_d = target;
                        state_d    = FETCH;
                    end else begin
                        state_d = TRAP;
                    end
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Outputs decode from registered state only
    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = (state_q == FETCH) ? fetch_pc_q : '0;
    assign bus.instr_valid = (state_q == HOLD);
    assign bus.trap        = (state_q == TRAP);
    assign bus.instr       = instr_q;
    assign bus.PC          = pc_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each acknowledged fetch pushes the
// expected {PC, instr} pair; each presented instruction pops and compares.
module tb_fetch_ctrl;
    localparam int          W   = 32;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    fetch_ctrl_if #(.WIDTH(W)) bus ();

    fetch_ctrl #(
        .WIDTH   (W),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_ret;
    logic [31:0] exp_pc;
    logic [31:0] tgt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Serve one fetch at addr after wait_cyc cycles of withheld ack,
    // then check the presented instruction against the scoreboard.
    task automatic do_fetch(input logic [31:0] addr, input int unsigned wait_cyc);
        logic [63:0] e;
        bus.imem_ack = 1'b0;
        chk("fetch_req", {31'd0, bus.imem_req}, 32'd1);
        chk("fetch_addr", bus.imem_addr, addr);
        chk("fetch_valid_lo", {31'd0, bus.instr_valid}, 32'd0);
        for (int unsigned i = 0; i < wait_cyc; i++) begin
            bus.stall = 1'b1;
            step();
            chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
            chk("wait_addr", bus.imem_addr, addr);
            chk("wait_valid", {31'd0, bus.instr_valid}, 32'd0);
        end
        bus.stall      = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(addr);
        sb_q.push_back({addr, mem_word(addr)});
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom();
        chk("valid_after_ack", {31'd0, bus.instr_valid}, 32'd1);
        chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
        if (bus.instr_valid === 1'b1 && sb_q.size() > 0) begin
            e      = sb_q.pop_front();
            exp_pc = e[63:32];
            chk("pc", bus.PC, e[63:32]);
            chk("instr", bus.instr, e[31:0]);
        end
    endtask

    // Hold with stall for `stalls` cycles (decoy branch inputs), then consume.
    task automatic consume(input logic src, input logic [31:0] imm,
                           input int unsigned stalls, output logic [31:0] target);
        bus.instr_ready = 1'b1;
        for (int unsigned i = 0; i < stalls; i++) begin
            bus.stall  = 1'b1;
            bus.PCSrc  = ~src;
            bus.ImmExt = imm ^ 32'h0000_0055;
            step();
            chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("stall_pc", bus.PC, exp_pc);
            chk("stall_instr", bus.instr, mem_word(exp_pc));
            chk("stall_ret", bus.retired, exp_ret);
            chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
        end
        bus.stall  = 1'b0;
        bus.PCSrc  = src;
        bus.ImmExt = imm;
        step();
        bus.instr_ready = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.ImmExt      = 32'hDEAD_BEEF;
        exp_ret++;
        target = exp_pc + (src ? imm : 32'd4);
        chk("retired", bus.retired, exp_ret);
    endtask

    task automatic wait_first_req();
        int unsigned n = 0;
        while (bus.imem_req !== 1'b1 && n < 2) begin
            step();
            n++;
        end
        chk("req_after_rst", {31'd0, bus.imem_req}, 32'd1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.stall       = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.ImmExt      = '0;
        exp_ret         = '0;
        exp_pc          = RPC;
        step();
        step();

        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_trap", {31'd0, bus.trap}, 32'd0);
        chk("rst_retired", bus.retired, 32'd0);
        chk("rst_pc", bus.PC, RPC);
        chk("rst_instr", bus.instr, 32'd0);

        rst = 1'b0;
        #1;
        chk("boot_req", {31'd0, bus.imem_req}, 32'd0);
        wait_first_req();

        // Sequential stream with ack always ready
        do_fetch(RPC, 0);
        consume(1'b0, 32'd0, 0, tgt);
        do_fetch(tgt, 0);
        consume(1'b0, 32'd0, 0, tgt);
        do_fetch(tgt, 0);
        consume(1'b0, 32'd0, 0, tgt);
        chk("retired_3", bus.retired, 32'd3);
        do_fetch(tgt, 0);
        consume(1'b1, 32'h0000_00F4, 0, tgt);

        // Backward branch from 0x100
        do_fetch(tgt, 0);
        chk("pc_0x100", bus.PC, 32'h0000_0100);
        consume(1'b1, 32'hFFFF_FFF0, 0, tgt);
        do_fetch(tgt, 4);
        chk("pc_0x0f0", bus.PC, 32'h0000_00F0);

        // Stalled hold, then branch to top of address space
        consume(1'b0, 32'd0, 5, tgt);
        do_fetch(tgt, 1);
        consume(1'b1, 32'hFFFF_FF08, 0, tgt);
        do_fetch(tgt, 0);
        chk("pc_top", bus.PC, 32'hFFFF_FFFC);
        consume(1'b0, 32'd0, 0, tgt);
        chk("wrap_req", {31'd0, bus.imem_req}, 32'd1);
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // Reset mid-fetch with an ack present
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        rst            = 1'b1;
        #1;
        chk("rst_fetch_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_fetch_ret", bus.retired, 32'd0);
        chk("rst_fetch_pc", bus.PC, RPC);
        step();
        chk("rst_ack_ignored", bus.instr, 32'd0);
        bus.imem_ack = 1'b0;
        rst          = 1'b0;
        exp_ret      = '0;
        wait_first_req();

        // Misaligned branch target traps
        do_fetch(RPC, 0);
        consume(1'b1, 32'h0000_0200, 0, tgt);
        do_fetch(tgt, 0);
        chk("pc_0x200", bus.PC, 32'h0000_0200);
        consume(1'b1, 32'h0000_0006, 0, tgt);
        chk("trap_set", {31'd0, bus.trap}, 32'd1);
        chk("trap_req", {31'd0, bus.imem_req}, 32'd0);
        chk("trap_valid", {31'd0, bus.instr_valid}, 32'd0);
        bus.imem_ack    = 1'b1;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("trap_sticky", {31'd0, bus.trap}, 32'd1);
            chk("trap_req_hold", {31'd0, bus.imem_req}, 32'd0);
            chk("trap_ret_hold", bus.retired, exp_ret);
        end
        rst = 1'b1;
        #1;
        chk("trap_cleared", {31'd0, bus.trap}, 32'd0);
        chk("trap_rst_ret", bus.retired, 32'd0);
        step();
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
        rst             = 1'b0;
        step();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
